// File: rtl/keypad_entry_ctrl_if.sv
// rtl/keypad_entry_ctrl_if.sv - key event inputs and entry/commit outputs of the keypad entry controller
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14,
    parameter int CNT_W  = 4
);
    logic                  key_hold;
    logic [3:0]            key_code;
    logic                  pset;
    logic [4*DIGITS-1:0]   entry_bcd;
    logic [CNT_W-1:0]      digit_cnt;
    logic [OUT_W-1:0]      num_set;
    logic                  set_valid;
    logic                  busy;

    modport master (
        output key_hold, key_code, pset,
        input  entry_bcd, digit_cnt, num_set, set_valid, busy
    );

    modport slave (
        input  key_hold, key_code, pset,
        output entry_bcd, digit_cnt, num_set, set_valid, busy
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad digit entry buffer with sequential BCD-to-binary commit
module keypad_entry_ctrl #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14,
    parameter int WRAP   = 1,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keypad_entry_ctrl_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q, state_d;
    logic               key_prev_q;
    logic [BCD_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   num_q, num_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               key_evt;
    logic [BCD_W-1:0]   shifted;
    logic [3:0]         cur_digit;
    logic [OUT_W-1:0]   acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_prev_q <= 1'b0;
            entry_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            num_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= bus.key_hold;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // The final CONV step writes num_set and set_valid directly so both are visible in the DONE cycle.
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        num_d     = num_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;

        key_evt   = key_prev_q & ~bus.key_hold;
        shifted   = entry_q >> {idx_q, 2'b00};
        cur_digit = shifted[3:0];
        acc_step  = acc_q * OUT_W'(10) + OUT_W'(cur_digit);

        case (state_q)
            IDLE: begin
                if (key_evt && bus.pset) begin
                    if (bus.key_code <= 4'd9) begin
                        if (cnt_q < CNT_W'(DIGITS)) begin
                            entry_d = (entry_q << 4) | BCD_W'(bus.key_code);
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else if (WRAP != 0) begin
                            entry_d = (entry_q << 4) | BCD_W'(bus.key_code);
                        end
                    end else begin
                        case (bus.key_code)
                            4'hA: begin
                                entry_d = '0;
                                cnt_d   = '0;
                            end
                            4'hB: begin
                                if (cnt_q != '0) begin
                                    entry_d = entry_q >> 4;
                                    cnt_d   = cnt_q - CNT_W'(1);
                                end
                            end
                            4'hC: begin
                                if (cnt_q != '0) begin
                                    acc_d   = '0;
                                    idx_d   = IDX_W'(DIGITS - 1);
                                    busy_d  = 1'b1;
                                    state_d = CONV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CONV: begin
                acc_d = acc_step;
                if (idx_q == '0) begin
                    num_d   = acc_step;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                entry_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.entry_bcd = entry_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.num_set   = num_q;
    assign bus.set_valid = valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - self-checking bench for keypad_entry_ctrl with WRAP=1 and WRAP=0 instances
module tb_keypad_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int OUT_W  = 14;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.DIGITS(DIGITS), .OUT_W(OUT_W), .CNT_W(CNT_W)) ia ();
    keypad_entry_ctrl_if #(.DIGITS(DIGITS), .OUT_W(OUT_W), .CNT_W(CNT_W)) ib ();

    keypad_entry_ctrl #(.DIGITS(DIGITS), .OUT_W(OUT_W), .WRAP(1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave)
    );
    keypad_entry_ctrl #(.DIGITS(DIGITS), .OUT_W(OUT_W), .WRAP(0), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave)
    );

    int checks = 0;
    int failures = 0;
    int qa[$];
    int qb[$];

    typedef struct {
        logic [3:0]  code;
        logic        pset;
        logic [15:0] exp_bcd;
        int          exp_cnt;
        logic        push;
        int          exp_a;
        int          exp_b;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hold, input logic [3:0] code, input logic ps);
        ia.key_hold = hold; ia.key_code = code; ia.pset = ps;
        ib.key_hold = hold; ib.key_code = code; ib.pset = ps;
    endtask

    task automatic press_key(input logic [3:0] code);
        drive(1'b1, code, ia.pset);
        cyc(2);
        drive(1'b0, code, ia.pset);
        cyc(1);
    endtask

    task automatic add_vec(input logic [3:0] code, input logic ps, input logic [15:0] bcd,
                           input int cnt, input logic push, input int ea, input int eb);
        vec_t v;
        v.code = code; v.pset = ps; v.exp_bcd = bcd; v.exp_cnt = cnt;
        v.push = push; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ia.set_valid) begin
                if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
                else chk("a_num_set", int'(ia.num_set), qa.pop_front());
            end
            if (ib.set_valid) begin
                if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
                else chk("b_num_set", int'(ib.num_set), qb.pop_front());
            end
        end
    end

    initial begin
        add_vec(4'h1, 1, 16'h0001, 1, 0, 0, 0);
        add_vec(4'h2, 1, 16'h0012, 2, 0, 0, 0);
        add_vec(4'h3, 1, 16'h0123, 3, 0, 0, 0);
        add_vec(4'h4, 1, 16'h1234, 4, 0, 0, 0);
        add_vec(4'h5, 1, 16'h2345, 4, 0, 0, 0);
        add_vec(4'hC, 1, 16'h0000, 0, 1, 2345, 1234);
        add_vec(4'h9, 1, 16'h0009, 1, 0, 0, 0);
        add_vec(4'h8, 1, 16'h0098, 2, 0, 0, 0);
        add_vec(4'h7, 1, 16'h0987, 3, 0, 0, 0);
        add_vec(4'hB, 1, 16'h0098, 2, 0, 0, 0);
        add_vec(4'h6, 1, 16'h0986, 3, 0, 0, 0);
        add_vec(4'hC, 1, 16'h0000, 0, 1, 986, 986);
        add_vec(4'h5, 1, 16'h0005, 1, 0, 0, 0);
        add_vec(4'h5, 1, 16'h0055, 2, 0, 0, 0);
        add_vec(4'hA, 1, 16'h0000, 0, 0, 0, 0);
        add_vec(4'h7, 1, 16'h0007, 1, 0, 0, 0);
        add_vec(4'hF, 1, 16'h0007, 1, 0, 0, 0);
        add_vec(4'hC, 1, 16'h0000, 0, 1, 7, 7);
        add_vec(4'hB, 1, 16'h0000, 0, 0, 0, 0);
        add_vec(4'h3, 0, 16'h0000, 0, 0, 0, 0);
        add_vec(4'h3, 0, 16'h0000, 0, 0, 0, 0);
        add_vec(4'hC, 1, 16'h0000, 0, 0, 0, 0);

        drive(1'b0, 4'h0, 1'b1);
        cyc(3);
        chk("reset_entry_bcd", int'(ia.entry_bcd), 0);
        chk("reset_digit_cnt", int'(ia.digit_cnt), 0);
        chk("reset_num_set", int'(ia.num_set), 0);
        chk("reset_set_valid", int'(ia.set_valid), 0);
        chk("reset_busy", int'(ia.busy), 0);
        rst_n = 1'b1;
        cyc(2);

        // Entry of 1234 and commit latency
        press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
        chk("lat_entry_bcd", int'(ia.entry_bcd), 16'h1234);
        chk("lat_digit_cnt", int'(ia.digit_cnt), 4);
        qa.push_back(1234); qb.push_back(1234);
        press_key(4'hC);
        chk("lat_busy_e1", int'(ia.busy), 1);
        chk("lat_valid_e1", int'(ia.set_valid), 0);
        for (int i = 2; i <= DIGITS; i++) begin
            cyc(1);
            chk("lat_busy_conv", int'(ia.busy), 1);
            chk("lat_valid_conv", int'(ia.set_valid), 0);
        end
        cyc(1);
        chk("lat_valid_done", int'(ia.set_valid), 1);
        chk("lat_busy_done", int'(ia.busy), 0);
        chk("lat_num_set", int'(ia.num_set), 1234);
        cyc(1);
        chk("lat_valid_after", int'(ia.set_valid), 0);
        chk("lat_entry_cleared", int'(ia.entry_bcd), 0);
        chk("lat_cnt_cleared", int'(ia.digit_cnt), 0);

        foreach (vecs[i]) begin
            drive(1'b0, ia.key_code, vecs[i].pset);
            if (vecs[i].push) begin
                qa.push_back(vecs[i].exp_a);
                qb.push_back(vecs[i].exp_b);
            end
            press_key(vecs[i].code);
            cyc((vecs[i].code == 4'hC) ? DIGITS + 3 : 1);
            chk($sformatf("vec%0d_entry_bcd", i), int'(ia.entry_bcd), int'(vecs[i].exp_bcd));
            chk($sformatf("vec%0d_digit_cnt", i), int'(ia.digit_cnt), vecs[i].exp_cnt);
        end
        chk("empty_enter_keeps_a", int'(ia.num_set), 7);
        chk("empty_enter_keeps_b", int'(ib.num_set), 7);
        chk("empty_enter_busy", int'(ia.busy), 0);

        // Key released during conversion must be dropped
        press_key(4'h0); press_key(4'h0); press_key(4'h4); press_key(4'h2);
        chk("lead0_entry_bcd", int'(ia.entry_bcd), 16'h0042);
        qa.push_back(42); qb.push_back(42);
        press_key(4'hC);
        drive(1'b1, 4'h8, 1'b1);
        cyc(1);
        drive(1'b0, 4'h8, 1'b1);
        cyc(DIGITS + 3);
        chk("discard_num_set", int'(ia.num_set), 42);
        chk("discard_entry_bcd", int'(ia.entry_bcd), 0);
        chk("discard_digit_cnt", int'(ia.digit_cnt), 0);

        // Reset in the middle of a conversion
        press_key(4'h5);
        press_key(4'hC);
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(ia.busy), 0);
        chk("arst_num_set", int'(ia.num_set), 0);
        chk("arst_set_valid", int'(ia.set_valid), 0);
        chk("arst_entry_bcd", int'(ia.entry_bcd), 0);
        chk("arst_digit_cnt", int'(ia.digit_cnt), 0);
        drive(1'b1, 4'h6, 1'b1);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        chk("held_no_event", int'(ia.digit_cnt), 0);
        drive(1'b0, 4'h6, 1'b1);
        cyc(1);
        chk("held_release_bcd", int'(ia.entry_bcd), 16'h0006);
        chk("held_release_cnt", int'(ia.digit_cnt), 1);
        cyc(3);
        chk("held_single_event", int'(ia.digit_cnt), 1);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
